// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: fetch-stage state encoding and instruction width.
// Also used by the control FSM, which observes fetch progress.
package cr16_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    CAP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with absolute load, signed relative add and increment.
// All arithmetic is modulo 2^ADDR_W.
module pc_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              add,
  input  logic [7:0]        disp,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] disp_ext;

  // Sign-extend the 8-bit displacement; the add then wraps naturally.
  assign disp_ext = {{(ADDR_W-8){disp[7]}}, disp};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (add) begin
      pc <= pc + disp_ext;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads one instruction word per request from synchronous RAM and
// hands it to the instruction register with a single-cycle ir_en pulse.
module instr_fetch
  import cr16_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MEM_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               branch_en,
  input  logic [7:0]         branch_disp,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               ir_en,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  localparam logic [1:0] WCNT_INIT = 2'(MEM_LAT - 1);

  fetch_state_t       state, state_nx;
  logic [1:0]         wcnt, wcnt_nx;
  logic [INSTR_W-1:0] instr_q;
  logic               capture;
  logic               pc_load, pc_add, pc_inc;

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (jump_addr),
    .add       (pc_add),
    .disp      (branch_disp),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      instr_q <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (capture) begin
        instr_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    capture  = 1'b0;
    pc_load  = 1'b0;
    pc_add   = 1'b0;
    pc_inc   = 1'b0;
    case (state)
      IDLE: begin
        // Redirect and fetch share an edge; the RD cycle then sees the new pc.
        if (jump_en) begin
          pc_load = 1'b1;
        end else if (branch_en) begin
          pc_add = 1'b1;
        end
        if (fetch_req) begin
          state_nx = RD;
        end
      end
      RD: begin
        state_nx = WAIT;
        wcnt_nx  = WCNT_INIT;
      end
      WAIT: begin
        if (wcnt == '0) begin
          capture  = 1'b1;
          state_nx = CAP;
        end else begin
          wcnt_nx = wcnt - 1'b1;
        end
      end
      CAP: begin
        pc_inc   = 1'b1;
        state_nx = fetch_req ? RD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr = pc;
  assign mem_rd   = (state == RD);
  assign ir_en    = (state == CAP);
  assign busy     = (state != IDLE);
  assign instr    = instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: two instances (MEM_LAT=1 and MEM_LAT=3)
// against a transaction-level model of PC redirects and fetched words.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // MEM_LAT=1 instance
  logic        fetch_req = 1'b0, jump_en = 1'b0, branch_en = 1'b0;
  logic [15:0] jump_addr = '0;
  logic [7:0]  branch_disp = '0;
  logic [15:0] mem_addr1, mem_rdata1, instr1, pc1;
  logic        mem_rd1, ir_en1, busy1;

  // MEM_LAT=3 instance (fetch requests only)
  logic        fetch_req3 = 1'b0, jump_en3 = 1'b0, branch_en3 = 1'b0;
  logic [15:0] jump_addr3 = '0;
  logic [7:0]  branch_disp3 = '0;
  logic [15:0] mem_addr3, mem_rdata3, instr3, pc3;
  logic        mem_rd3, ir_en3, busy3;

  logic [15:0] mem [65536];
  logic [15:0] a1 = '0;
  logic        v1 = 1'b0;
  logic [15:0] a3 [3];
  logic        v3 [3];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int          sel_v    = 0;
  logic [15:0] m_pc [2];
  logic        prev_ir1 = 1'b0, prev_ir3 = 1'b0;

  logic [15:0] o_mem_addr, o_instr, o_pc;
  logic        o_mem_rd, o_ir_en, o_busy;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .jump_en(jump_en),
    .jump_addr(jump_addr), .branch_en(branch_en), .branch_disp(branch_disp),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_rdata(mem_rdata1),
    .instr(instr1), .ir_en(ir_en1), .pc(pc1), .busy(busy1)
  );

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req3), .jump_en(jump_en3),
    .jump_addr(jump_addr3), .branch_en(branch_en3), .branch_disp(branch_disp3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_rdata(mem_rdata3),
    .instr(instr3), .ir_en(ir_en3), .pc(pc3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // Synchronous RAM models: data is valid only MEM_LAT cycles after the read cycle.
  always @(posedge clk) begin
    a1    <= mem_addr1;
    v1    <= mem_rd1;
    a3[0] <= mem_addr3;
    v3[0] <= mem_rd3;
    a3[1] <= a3[0];
    v3[1] <= v3[0];
    a3[2] <= a3[1];
    v3[2] <= v3[1];
  end
  assign mem_rdata1 = v1    ? mem[a1]    : 16'hDEAD;
  assign mem_rdata3 = v3[2] ? mem[a3[2]] : 16'hDEAD;

  assign o_mem_addr = (sel_v != 0) ? mem_addr3 : mem_addr1;
  assign o_instr    = (sel_v != 0) ? instr3    : instr1;
  assign o_pc       = (sel_v != 0) ? pc3       : pc1;
  assign o_mem_rd   = (sel_v != 0) ? mem_rd3   : mem_rd1;
  assign o_ir_en    = (sel_v != 0) ? ir_en3    : ir_en1;
  assign o_busy     = (sel_v != 0) ? busy3     : busy1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ir_en must never stay high across two consecutive cycles.
  always @(negedge clk) begin
    if (prev_ir1) check("ir_en_single_1", {31'b0, ir_en1}, 32'd0);
    if (prev_ir3) check("ir_en_single_3", {31'b0, ir_en3}, 32'd0);
    prev_ir1 <= ir_en1;
    prev_ir3 <= ir_en3;
  end

  task automatic redirect(input logic jmp, input logic [15:0] ja, input logic br, input logic [7:0] bd);
    sel_v = 0;
    jump_en = jmp; jump_addr = ja; branch_en = br; branch_disp = bd;
    tick();
    jump_en = 1'b0; branch_en = 1'b0;
    if (jmp)     m_pc[0] = ja;
    else if (br) m_pc[0] = m_pc[0] + {{8{bd[7]}}, bd};
    check("redir_pc", o_pc, m_pc[0]);
    check("redir_busy", o_busy, 0);
  endtask

  task automatic run_fetch(input int sel, input logic jmp, input logic [15:0] ja,
                           input logic br, input logic [7:0] bd, input logic late);
    logic [15:0] tgt;
    int          lat;
    int          n;
    sel_v = sel;
    lat   = (sel != 0) ? 3 : 1;
    if (jmp)     tgt = ja;
    else if (br) tgt = m_pc[sel] + {{8{bd[7]}}, bd};
    else         tgt = m_pc[sel];
    check("idle_busy", o_busy, 0);
    if (sel != 0) begin
      fetch_req3 = 1'b1;
    end else begin
      jump_en = jmp; jump_addr = ja; branch_en = br; branch_disp = bd; fetch_req = 1'b1;
    end
    tick();
    fetch_req = 1'b0; fetch_req3 = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    check("rd_strobe", o_mem_rd, 1);
    check("rd_addr", o_mem_addr, tgt);
    check("rd_busy", o_busy, 1);
    n = 0;
    while (!o_ir_en && n < 12) begin
      if (late && sel == 0) begin
        jump_en = 1'b1; jump_addr = ~tgt; branch_en = 1'b1; branch_disp = 8'h10;
      end
      tick();
      n++;
    end
    check("cap_latency", n, lat + 1);
    check("cap_instr", o_instr, mem[tgt]);
    check("cap_pc", o_pc, tgt);
    tick();
    jump_en = 1'b0; branch_en = 1'b0;
    m_pc[sel] = tgt + 16'd1;
    check("post_ir_en", o_ir_en, 0);
    check("post_busy", o_busy, 0);
    check("post_pc", o_pc, m_pc[sel]);
    check("post_instr", o_instr, mem[tgt]);
  endtask

  task automatic back_to_back(input int count);
    logic [15:0] base;
    int unsigned last;
    int          n;
    sel_v = 0;
    base  = m_pc[0];
    last  = 0;
    fetch_req = 1'b1;
    tick();
    for (int i = 0; i < count; i++) begin
      n = 0;
      while (!o_ir_en && n < 12) begin
        tick();
        n++;
      end
      if (i == 0) check("b2b_first_latency", n, 2);
      else        check("b2b_spacing", cyc - last, 3);
      last = cyc;
      check("b2b_instr", o_instr, mem[base + 16'(i)]);
      check("b2b_pc", o_pc, base + 16'(i));
      if (i == count - 1) fetch_req = 1'b0;
      tick();
    end
    m_pc[0] = base + 16'(count);
    check("b2b_end_busy", o_busy, 0);
    check("b2b_end_pc", o_pc, m_pc[0]);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a3[i] = '0;
      v3[i] = 1'b0;
    end
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    m_pc[0] = '0;
    m_pc[1] = '0;

    // Reset state
    #12;
    check("rst_pc", pc1, 0);
    check("rst_instr", instr1, 0);
    check("rst_ir_en", ir_en1, 0);
    check("rst_mem_rd", mem_rd1, 0);
    check("rst_mem_addr", mem_addr1, 0);
    check("rst_busy", busy1, 0);
    rst = 1'b1;
    tick();

    // Single fetch
    mem[0] = 16'h1234;
    run_fetch(0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);

    // Back-to-back from address 0
    redirect(1'b1, 16'h0000, 1'b0, 8'h00);
    mem[0] = 16'hA001; mem[1] = 16'hB002; mem[2] = 16'hC003;
    back_to_back(3);

    // Jump + fetch on the same edge; then jump beats a simultaneous branch
    mem[16'h0040] = 16'h5A5A;
    run_fetch(0, 1'b1, 16'h0040, 1'b0, 8'h00, 1'b0);
    run_fetch(0, 1'b1, 16'h0040, 1'b1, 8'h7F, 1'b0);

    // Negative branch wraps below zero; increments wrap past all-ones
    redirect(1'b1, 16'h0002, 1'b0, 8'h00);
    redirect(1'b0, 16'h0000, 1'b1, 8'hFC);
    check("branch_wrap_pc", pc1, 16'hFFFE);
    run_fetch(0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    run_fetch(0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    check("inc_wrap_pc", pc1, 16'h0000);

    // Redirects outside IDLE are ignored
    run_fetch(0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);

    // Randomised redirect/fetch mix
    for (int i = 0; i < 24; i++) begin
      run_fetch(0, ($urandom_range(0, 3) == 0), 16'($urandom), ($urandom_range(0, 2) == 0),
                8'($urandom), ($urandom_range(0, 3) == 0));
    end

    // MEM_LAT=3: complete one fetch, then reset asynchronously mid-WAIT
    run_fetch(1, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    sel_v = 1;
    fetch_req3 = 1'b1;
    tick();
    fetch_req3 = 1'b0;
    tick();
    tick();
    check("mid_wait_busy", busy3, 1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy", busy3, 0);
    check("arst_ir_en", ir_en3, 0);
    check("arst_mem_rd", mem_rd3, 0);
    check("arst_pc", pc3, 0);
    check("arst_mem_addr", mem_addr3, 0);
    check("arst_instr", instr3, 0);
    check("arst_pc_other", pc1, 0);
    m_pc[0] = '0;
    m_pc[1] = '0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("aborted_no_ir_en", ir_en3, 0);
      check("aborted_pc", pc3, 0);
    end
    run_fetch(1, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    run_fetch(0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
